// File: rtl/sky130_sram_pkg.sv
// Shared sizing constants and word/address/mask types for the SKY130 1rw1r SRAM model.
package sky130_sram_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 9;
  localparam int NUM_WMASKS = DATA_WIDTH / 8;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [NUM_WMASKS-1:0] wmask_t;

endpackage : sky130_sram_pkg

// File: rtl/sky130_sram_read_port.sv
// One registered read path: latches chip select and address on the rising edge and
// captures the addressed array word into dout; dout holds while deselected.
module sky130_sram_read_port
  import sky130_sram_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          csb,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] rd_data,
  output logic          sel_q,
  output logic [AW-1:0] addr_q,
  output logic [DW-1:0] dout
);

  // NOTE: non-blocking updates here sample the array before any same-edge write lands,
  // which is what gives read-before-write on a port collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q  <= 1'b0;
      addr_q <= '0;
      dout   <= '0;
    end else begin
      sel_q <= ~csb;
      if (!csb) begin
        addr_q <= addr;
        dout   <= rd_data;
      end
    end
  end

endmodule : sky130_sram_read_port

// File: rtl/sky130_sram_1rw1r_32x512.sv
// Behavioural SKY130 dual-port SRAM: port 0 read/write with byte mask, port 1 read-only.
// Optional SKY130_SRAM_POWER_PINS_EN adds vccd1/vssd1; outputs go X and writes stop when unpowered.
module sky130_sram_1rw1r_32x512
  import sky130_sram_pkg::*;
#(
  parameter int DATA_WIDTH = sky130_sram_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = sky130_sram_pkg::ADDR_WIDTH,
  parameter int NUM_WMASKS = DATA_WIDTH / 8
) (
`ifdef SKY130_SRAM_POWER_PINS_EN
  inout  wire                   vccd1,
  inout  wire                   vssd1,
`endif
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1
);

  localparam int MEM_DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  powered;
  logic                  rd0_csb;
  logic                  wr0_en;
  logic [DATA_WIDTH-1:0] rd0_data;
  logic [DATA_WIDTH-1:0] rd1_data;
  logic [DATA_WIDTH-1:0] dout0_q;
  logic [DATA_WIDTH-1:0] dout1_q;
  logic                  rd0_sel_q;
  logic                  rd1_sel_q;
  logic [ADDR_WIDTH-1:0] rd0_addr_q;
  logic [ADDR_WIDTH-1:0] rd1_addr_q;

`ifdef SKY130_SRAM_POWER_PINS_EN
  assign powered = (vccd1 === 1'b1) && (vssd1 === 1'b0);
  assign dout0   = powered ? dout0_q : 'x;
  assign dout1   = powered ? dout1_q : 'x;
`else
  assign powered = 1'b1;
  assign dout0   = dout0_q;
  assign dout1   = dout1_q;
`endif

  // Port 0 only reads when selected with web0 high; a write leaves dout0 untouched.
  assign rd0_csb  = csb0 | ~web0;
  assign wr0_en   = powered & ~csb0 & ~web0;
  assign rd0_data = mem[addr0];
  assign rd1_data = mem[addr1];

  // NOTE: the array has no reset; the reset branch only blocks writes while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
    end else if (wr0_en) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i]) mem[addr0][8*i +: 8] <= din0[8*i +: 8];
      end
    end
  end

  sky130_sram_read_port #(
    .DW (DATA_WIDTH),
    .AW (ADDR_WIDTH)
  ) u_rd0 (
    .clk     (clk),
    .rst     (rst),
    .csb     (rd0_csb),
    .addr    (addr0),
    .rd_data (rd0_data),
    .sel_q   (rd0_sel_q),
    .addr_q  (rd0_addr_q),
    .dout    (dout0_q)
  );

  sky130_sram_read_port #(
    .DW (DATA_WIDTH),
    .AW (ADDR_WIDTH)
  ) u_rd1 (
    .clk     (clk),
    .rst     (rst),
    .csb     (csb1),
    .addr    (addr1),
    .rd_data (rd1_data),
    .sel_q   (rd1_sel_q),
    .addr_q  (rd1_addr_q),
    .dout    (dout1_q)
  );

  // Two reads of one address on the same edge must return the same word.
  same_addr_same_word: assert property (
    @(posedge clk) disable iff (!rst)
      (rd0_sel_q && rd1_sel_q && (rd0_addr_q == rd1_addr_q)) |-> (dout0_q === dout1_q)
  );

endmodule : sky130_sram_1rw1r_32x512

// File: tb/tb_sky130_sram_1rw1r_32x512.sv
// Directed self-checking bench for the SKY130 1rw1r 32x512 SRAM model.
module tb_sky130_sram_1rw1r_32x512;

  logic        clk;
  logic        rst;
  logic        csb0;
  logic        web0;
  logic [3:0]  wmask0;
  logic [8:0]  addr0;
  logic [31:0] din0;
  logic [31:0] dout0;
  logic        csb1;
  logic [8:0]  addr1;
  logic [31:0] dout1;

  int total = 0;
  int bad   = 0;

`ifdef SKY130_SRAM_POWER_PINS_EN
  wire vccd1 = 1'b1;
  wire vssd1 = 1'b0;
`endif

  sky130_sram_1rw1r_32x512 dut (
`ifdef SKY130_SRAM_POWER_PINS_EN
    .vccd1  (vccd1),
    .vssd1  (vssd1),
`endif
    .clk    (clk),
    .rst    (rst),
    .csb0   (csb0),
    .web0   (web0),
    .wmask0 (wmask0),
    .addr0  (addr0),
    .din0   (din0),
    .dout0  (dout0),
    .csb1   (csb1),
    .addr1  (addr1),
    .dout1  (dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive both ports at a falling edge, let one rising edge pass, return at the next falling edge.
  task automatic step(input logic c0, input logic w0, input logic [3:0] m, input logic [8:0] a0,
                      input logic [31:0] d, input logic c1, input logic [8:0] a1);
    csb0   = c0;
    web0   = w0;
    wmask0 = m;
    addr0  = a0;
    din0   = d;
    csb1   = c1;
    addr1  = a1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] m);
    step(1'b0, 1'b0, m, a, d, 1'b1, 9'd0);
  endtask

  task automatic rd(input logic [8:0] a0, input logic [8:0] a1);
    step(1'b0, 1'b1, 4'h0, a0, 32'h0, 1'b0, a1);
  endtask

  initial begin
    rst    = 1'b0;
    csb0   = 1'b1;
    web0   = 1'b1;
    wmask0 = 4'h0;
    addr0  = '0;
    din0   = '0;
    csb1   = 1'b1;
    addr1  = '0;
    @(negedge clk);
    check("reset_dout0", dout0, 32'h0);
    check("reset_dout1", dout1, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Known contents at the top address for the collision case.
    wr(9'd511, 32'h0000_0000, 4'hF);

    wr(9'd5, 32'hDEAD_BEEF, 4'hF);
    rd(9'd5, 9'd0);
    check("full_write_read", dout0, 32'hDEAD_BEEF);

    wr(9'd5, 32'h1122_3344, 4'b0101);
    rd(9'd5, 9'd5);
    check("masked_write_p0", dout0, 32'hDE22_BE44);
    check("masked_write_p1", dout1, 32'hDE22_BE44);

    // Empty mask: legal write that changes nothing; dout0 holds through it.
    wr(9'd5, 32'hFFFF_FFFF, 4'h0);
    check("nomask_hold", dout0, 32'hDE22_BE44);
    rd(9'd5, 9'd5);
    check("nomask_unchanged", dout0, 32'hDE22_BE44);

    // Collision: port 1 sees the old word, the write still lands.
    step(1'b0, 1'b0, 4'hF, 9'd511, 32'hA5A5_A5A5, 1'b0, 9'd511);
    check("collision_old", dout1, 32'h0000_0000);
    check("collision_p0_hold", dout0, 32'hDE22_BE44);
    rd(9'd5, 9'd511);
    check("collision_new", dout1, 32'hA5A5_A5A5);

    wr(9'd7, 32'h1234_5678, 4'hF);
    rd(9'd7, 9'd511);
    check("addr7_written", dout0, 32'h1234_5678);
    step(1'b1, 1'b0, 4'hF, 9'd7, 32'hFFFF_FFFF, 1'b1, 9'd0);
    check("deselect_hold", dout0, 32'h1234_5678);
    rd(9'd7, 9'd511);
    check("deselect_nowrite", dout0, 32'h1234_5678);

    wr(9'd0, 32'hCAFE_F00D, 4'hF);
    wr(9'd511, 32'h0BAD_C0DE, 4'hF);
    rd(9'd0, 9'd511);
    check("bottom_addr", dout0, 32'hCAFE_F00D);
    check("top_addr", dout1, 32'h0BAD_C0DE);
    step(1'b0, 1'b1, 4'h0, 9'd511, 32'h0, 1'b1, 9'd0);
    check("p0_top_addr", dout0, 32'h0BAD_C0DE);
    check("p1_deselect_hold", dout1, 32'h0BAD_C0DE);

    // Asynchronous reset mid-cycle, with a write attempted while it is held.
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_dout0", dout0, 32'h0);
    check("async_reset_dout1", dout1, 32'h0);
    @(negedge clk);
    step(1'b0, 1'b0, 4'hF, 9'd5, 32'h0000_0000, 1'b0, 9'd0);
    check("reset_blocks_read", dout1, 32'h0);
    rst = 1'b1;
    rd(9'd5, 9'd0);
    check("after_reset_p0", dout0, 32'hDE22_BE44);
    check("after_reset_p1", dout1, 32'hCAFE_F00D);

    step(1'b1, 1'b1, 4'h0, 9'd0, 32'h0, 1'b1, 9'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sky130_sram_1rw1r_32x512
